// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared store-size codes (decoder encodings), store-unit
//                state encoding and a size-normalisation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Store size codes, identical to the store-instruction decoder encodings
    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    // Store-unit state encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DONE  = 3'd2,
        FAULT = 3'd3,
        TOUT  = 3'd4
    } st_state_e;

    // Any code that is not a half or word store behaves as a byte store
    function automatic logic [2:0] norm_size(input logic [2:0] code);
        return ((code == SH) || (code == SW)) ? code : SB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_align
//  Description : Combinational byte-lane steering for stores. Replicates the
//                store data across lanes, builds the byte strobes from the
//                low address bits and flags misaligned half/word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  ea_lo,
    input  logic [2:0]  size,
    input  logic [31:0] rs2_val,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    // Lane replication and strobe generation per normalised store size
    always_comb begin
        wdata      = {4{rs2_val[7:0]}};
        wstrb      = 4'b0001 << ea_lo;
        misaligned = 1'b0;
        case (norm_size(size))
            SH: begin
                wdata      = {2{rs2_val[15:0]}};
                wstrb      = 4'b0011 << {ea_lo[1], 1'b0};
                misaligned = ea_lo[0];
            end
            SW: begin
                wdata      = rs2_val;
                wstrb      = 4'b1111;
                misaligned = |ea_lo;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_unit
//  Description : Store execution stage. Computes the effective address,
//                checks alignment, issues one byte-laned write over a req/ack
//                handshake and reports done / misaligned / timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_unit
    import riscv_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [11:0] imm,
    input  logic [2:0]  store_control,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_misaligned,
    output logic        st_timeout,
    output logic [31:0] st_fault_addr
);

    // Last wait-counter value before the request is abandoned
    localparam logic [7:0] c_WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    st_state_e   r_state;
    st_state_e   w_next;
    logic [31:0] r_ea;
    logic [31:0] r_rs2;
    logic [2:0]  r_size;
    logic [7:0]  r_wait;
    logic [31:0] r_fault_addr;

    logic        w_idle;
    logic        w_accept;
    logic [31:0] w_ea;
    logic [1:0]  w_sel_ea_lo;
    logic [2:0]  w_sel_size;
    logic [31:0] w_sel_rs2;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_misaligned;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = st_valid && w_idle;
    assign w_ea     = rs1_val + {{20{imm[11]}}, imm};

    // The aligner sees the incoming store while idle (for the fault decision)
    // and the registered store otherwise (for lane generation in REQ).
    assign w_sel_ea_lo = w_idle ? w_ea[1:0]     : r_ea[1:0];
    assign w_sel_size  = w_idle ? store_control : r_size;
    assign w_sel_rs2   = w_idle ? rs2_val       : r_rs2;

    store_lane_align u_align (
        .ea_lo      (w_sel_ea_lo),
        .size       (w_sel_size),
        .rs2_val    (w_sel_rs2),
        .wdata      (w_wdata),
        .wstrb      (w_wstrb),
        .misaligned (w_misaligned)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an ack in the last allowed cycle beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_next = DONE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next = TOUT;
                end
            end
            DONE:    w_next = IDLE;
            FAULT:   w_next = IDLE;
            TOUT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode; memory bus is held at zero outside REQ
    always_comb begin
        st_ready      = w_idle;
        mem_req       = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        mem_wstrb     = 4'd0;
        st_done       = (r_state == DONE);
        st_misaligned = (r_state == FAULT);
        st_timeout    = (r_state == TOUT);
        if (r_state == REQ) begin
            mem_req   = 1'b1;
            mem_addr  = {r_ea[31:2], 2'b00};
            mem_wdata = w_wdata;
            mem_wstrb = w_wstrb;
        end
    end

    // Capture the store operands on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ea   <= 32'd0;
            r_rs2  <= 32'd0;
            r_size <= SB;
        end else if (w_accept) begin
            r_ea   <= w_ea;
            r_rs2  <= rs2_val;
            r_size <= norm_size(store_control);
        end
    end

    // Wait counter: cleared on accept, counts REQ cycles without ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 8'd0;
        end else if (w_accept) begin
            r_wait <= 8'd0;
        end else if ((r_state == REQ) && !mem_ack) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Fault address is loaded as the FSM enters FAULT or TOUT, so it is
    // already valid during the corresponding pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_addr <= 32'd0;
        end else if (w_idle && (w_next == FAULT)) begin
            r_fault_addr <= w_ea;
        end else if ((r_state == REQ) && (w_next == TOUT)) begin
            r_fault_addr <= r_ea;
        end
    end

    assign st_fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: doc/store_unit.md
# store_unit

Store execution stage directly downstream of the store-instruction decoder. Takes the decoded store (base register value, data register value, 12-bit immediate, store size code), computes the effective address, checks alignment, and issues one byte-laned write to data memory over a req/ack handshake. Reports completion, misalignment and memory timeout to the pipeline control.

## Interface
- `ACK_TIMEOUT`, default 16: maximum cycles `mem_req` may stay high without `mem_ack` before the store is abandoned. Valid range is 1..255.

- `clk` in 1: single clock. All state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: store request from upstream.
- `st_ready` out 1: high exactly when state is IDLE.
- `rs1_val` in 32: base address.
- `rs2_val` in 32: store data.
- `imm` in 12: signed offset.
- `store_control` in 3: store size code, using the decoder encodings `SB`, `SH`, `SW`.
- `mem_req` out 1: write request.
- `mem_addr` out 32: word-aligned address. Bits [1:0] are always 0.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_wstrb` out 4: byte enables.
- `mem_ack` in 1: write accepted.
- `st_done` out 1: one-cycle pulse on successful completion.
- `st_misaligned` out 1: one-cycle pulse on an alignment fault.
- `st_timeout` out 1: one-cycle pulse on an ack timeout.
- `st_fault_addr` out 32: effective address of the last faulting store. Holds its value until the next fault.

## Operation
- Accept: a request is accepted when `st_valid && st_ready` at a rising edge.
- On accept, the block registers:
  - effective address `ea = rs1_val + sext(imm)`, computed modulo 2^32 (wrap-around is legal);
  - `rs2_val`;
  - the size code. Any code other than `SH` or `SW` is treated as `SB`.
- Alignment rules:
  - `SH` faults if `ea[0]` is 1.
  - `SW` faults if `ea[1:0]` is nonzero.
  - `SB` never faults.
- State machine:
  - IDLE: on accept, go to FAULT if misaligned, otherwise go to REQ.
  - FAULT: pulse `st_misaligned` and load `st_fault_addr = ea`. No memory request is made. Go to IDLE next cycle.
  - REQ: drive `mem_req=1`. A 8-bit wait counter starts at 0 and increments each REQ cycle without ack.
    - If `mem_ack` is high, go to DONE.
    - Else if the counter reaches `ACK_TIMEOUT-1`, go to TOUT.
  - DONE: pulse `st_done`. Go to IDLE.
  - TOUT: pulse `st_timeout` and load `st_fault_addr = ea`. Go to IDLE.
- Lane generation while in REQ:
  - `mem_addr = {ea[31:2], 2'b00}`.
  - SB: `wdata = {4{rs2[7:0]}}`, `wstrb = 4'b0001 << ea[1:0]`.
  - SH: `wdata = {2{rs2[15:0]}}`, `wstrb = 4'b0011 << {ea[1], 1'b0}`.
  - SW: `wdata = rs2`, `wstrb = 4'b1111`.
- Outside REQ, `mem_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` are all 0.
- `mem_ack` is ignored while `mem_req` is low.
- `st_valid` is ignored when `st_ready` is low. Upstream must hold the request until it is accepted.

## Timing
- Reset values:
  - state IDLE, so `st_ready=1`;
  - `mem_req`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0;
  - all pulse outputs = 0;
  - `st_fault_addr` = 0;
  - counter = 0.
- Reset asserted mid-REQ: `mem_req` drops immediately (asynchronously). No done or timeout pulse is produced.
- Best-case successful store (ack in the first REQ cycle):
  - accept at edge N;
  - `mem_req` high in cycle N+1;
  - ack sampled at edge N+2;
  - `st_done` high in cycle N+2;
  - `st_ready` high again in cycle N+3.
- Throughput: at most one store every 3 cycles.
- Misaligned store: accept at edge N; `st_misaligned` high in cycle N+1; `st_ready` high in cycle N+2.
- Timeout: `mem_req` is held for exactly `ACK_TIMEOUT` cycles, then `st_timeout` pulses for one cycle.
- Ack arriving in the final allowed cycle: the ack wins. The store completes with `st_done`, not `st_timeout`.
- `mem_req` is high for at least one cycle and deasserts the cycle after the ack is sampled.

## Structure
- Shared package `riscv_pkg` holds:
  - the store size codes `SB=3'd0`, `SH=3'd1`, `SW=3'd2`, identical to the decoder encodings;
  - the state enum `{IDLE, REQ, DONE, FAULT, TOUT}`.
- One combinational sub-module, `store_lane_align`. It takes `ea[1:0]`, the size code and `rs2_val`, and produces `wdata`, `wstrb` and the misaligned flag.
- The FSM, wait counter and registers live in `store_unit`.

## Test plan
- SW word store: `rs1=0x1000`, `imm=0x004`, `rs2=0xDEADBEEF`, ack in the first REQ cycle. Expect `addr=0x1004`, `wdata=0xDEADBEEF`, `wstrb=4'b1111`; `st_done` in cycle N+2.
- SB with negative imm: `rs1=0x1003`, `imm=12'hFFF`, `rs2=0x000000A5`. Expect `ea=0x1002`, `addr=0x1000`, `wdata=0xA5A5A5A5`, `wstrb=4'b0100`.
- SH misaligned: `rs1=0x2001`, `imm=0`. Expect `st_misaligned` in cycle N+1, `st_fault_addr=0x2001`, and `mem_req` never asserted.
- Timeout with `ACK_TIMEOUT=4`, no ack: `mem_req` high for exactly 4 cycles, then `st_timeout` pulse. Repeat with ack in the 4th cycle: expect `st_done` and no `st_timeout`.
- Reset mid-transaction: assert `rst_n` low during REQ. Expect `mem_req=0` immediately, `st_ready=1` after release, and no pulses.
- Address wrap and back-to-back stores:
  - `rs1=0xFFFFFFFE`, `imm=0x004`, SH: expect `ea=0x00000002`, `wstrb=4'b1100`.
  - Second store with `st_valid` held continuously: accepted in the cycle after the `st_done` pulse.
